// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use / branch-in-ID
// interlocks, taken-branch IF/ID flush, data-memory freeze and perf counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       RS1Addr_ID,
  input  logic [4:0]       RS2Addr_ID,
  input  logic             UseRS1_ID,
  input  logic             UseRS2_ID,
  input  logic             Branch_ID,
  input  logic             BranchTaken_ID,
  input  logic [4:0]       RDAddr_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       RDAddr_MEM,
  input  logic             MemRead_MEM,
  input  logic             MemReq_MEM,
  input  logic             MemAck_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             Freeze_o,
  output logic [CNT_W-1:0] StallCount_o,
  output logic [CNT_W-1:0] FlushCount_o
);

  // state    | meaning
  // S_OFF    | core not running, all controls low, counters held
  // S_RUN    | normal operation, hazards resolved every cycle
  // S_MEM_WAIT | data-memory access outstanding, waiting for MemAck_i
  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t r_state;
  state_t w_state_nxt;

  logic w_active;
  logic w_mem_pending;
  logic w_freeze;
  logic w_match_ex;
  logic w_match_mem;
  logic w_load_use;
  logic w_br_alu;
  logic w_br_load;
  logic w_data_stall;
  logic w_stall_cycle;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_active      = (r_state != S_OFF);
  assign w_mem_pending = MemReq_MEM && !MemAck_i;
  assign w_freeze      = w_active && w_mem_pending;

  assign w_match_ex  = (RDAddr_EX != 5'd0) &&
                       ((UseRS1_ID && (RDAddr_EX == RS1Addr_ID)) ||
                        (UseRS2_ID && (RDAddr_EX == RS2Addr_ID)));
  assign w_match_mem = (RDAddr_MEM != 5'd0) &&
                       ((UseRS1_ID && (RDAddr_MEM == RS1Addr_ID)) ||
                        (UseRS2_ID && (RDAddr_MEM == RS2Addr_ID)));

  assign w_load_use   = MemRead_EX && w_match_ex;
  assign w_br_alu     = Branch_ID && RegWrite_EX && w_match_ex;
  assign w_br_load    = Branch_ID && MemRead_MEM && w_match_mem;
  assign w_data_stall = w_load_use || w_br_alu || w_br_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start_i is deliberately not looked at in S_MEM_WAIT; a drop is seen back in S_RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OFF: begin
        if (start_i) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_mem_pending) w_state_nxt = S_MEM_WAIT;
        else if (!start_i) w_state_nxt = S_OFF;
      end
      S_MEM_WAIT: begin
        if (MemAck_i) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  always_comb begin
    PCWrite_o    = 1'b0;
    IFIDWrite_o  = 1'b0;
    IFIDFlush_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    Freeze_o     = 1'b0;
    if (w_active) begin
      if (w_freeze) begin
        Freeze_o = 1'b1;
      end else if (w_data_stall) begin
        IDEXBubble_o = 1'b1;
      end else begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        IFIDFlush_o = BranchTaken_ID;
      end
    end
  end

  assign w_stall_cycle = w_active && !PCWrite_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_cycle && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (IFIDFlush_o && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign StallCount_o = r_stall_cnt;
  assign FlushCount_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i, start_i;
  logic [4:0] RS1Addr_ID, RS2Addr_ID, RDAddr_EX, RDAddr_MEM;
  logic UseRS1_ID, UseRS2_ID, Branch_ID, BranchTaken_ID;
  logic RegWrite_EX, MemRead_EX, MemRead_MEM, MemReq_MEM, MemAck_i;
  logic PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, Freeze_o;
  logic [CNT_W-1:0] StallCount_o, FlushCount_o;

  int errors = 0;
  int checks = 0;

  // reference model: mode 0=off, 1=running, 2=waiting on memory
  int m_mode = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .RS1Addr_ID(RS1Addr_ID), .RS2Addr_ID(RS2Addr_ID),
    .UseRS1_ID(UseRS1_ID), .UseRS2_ID(UseRS2_ID),
    .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
    .RDAddr_EX(RDAddr_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .RDAddr_MEM(RDAddr_MEM), .MemRead_MEM(MemRead_MEM),
    .MemReq_MEM(MemReq_MEM), .MemAck_i(MemAck_i),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .IFIDFlush_o(IFIDFlush_o),
    .IDEXBubble_o(IDEXBubble_o), .Freeze_o(Freeze_o),
    .StallCount_o(StallCount_o), .FlushCount_o(FlushCount_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] rd);
    return rd != 0 && ((UseRS1_ID && rd == RS1Addr_ID) || (UseRS2_ID && rd == RS2Addr_ID));
  endfunction

  // expected {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Freeze}
  function automatic logic [4:0] exp_ctrl();
    bit hazard;
    if (m_mode == 0) return 5'b00000;
    if (MemReq_MEM && !MemAck_i) return 5'b00001;
    hazard = (MemRead_EX && reads(RDAddr_EX)) ||
             (Branch_ID && RegWrite_EX && reads(RDAddr_EX)) ||
             (Branch_ID && MemRead_MEM && reads(RDAddr_MEM));
    if (hazard) return 5'b00010;
    if (BranchTaken_ID) return 5'b11100;
    return 5'b11000;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Compares this cycle's outputs, then advances the model across the edge.
  task automatic run_cycle();
    logic [4:0] e;
    #1;
    e = exp_ctrl();
    check("ctrl", {PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, Freeze_o}, e);
    check("stall_cnt", StallCount_o, m_stall);
    check("flush_cnt", FlushCount_o, m_flush);
    @(posedge clk_i);
    if (rst_i) begin
      m_mode = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_mode != 0 && !e[4]) m_stall = sat_inc(m_stall);
      if (e[2]) m_flush = sat_inc(m_flush);
      case (m_mode)
        0: if (start_i) m_mode = 1;
        1: if (MemReq_MEM && !MemAck_i) m_mode = 2; else if (!start_i) m_mode = 0;
        default: if (MemAck_i) m_mode = 1;
      endcase
    end
    @(negedge clk_i);
  endtask

  task automatic clear_id();
    RS1Addr_ID = 0; RS2Addr_ID = 0; UseRS1_ID = 0; UseRS2_ID = 0;
    Branch_ID = 0; BranchTaken_ID = 0; RDAddr_EX = 0; RegWrite_EX = 0;
    MemRead_EX = 0; RDAddr_MEM = 0; MemRead_MEM = 0; MemReq_MEM = 0; MemAck_i = 0;
  endtask

  task automatic load_use5();
    RDAddr_EX = 5; MemRead_EX = 1; RS2Addr_ID = 5; UseRS2_ID = 1;
  endtask

  initial begin
    rst_i = 1; start_i = 0; clear_id();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;

    // start for one cycle: OFF outputs, then RUN
    start_i = 1;
    run_cycle();
    check("off_cnt", {StallCount_o, FlushCount_o}, 0);
    run_cycle();

    // load-use on rs2
    load_use5();
    #1 check("lu_bubble", {PCWrite_o, IDEXBubble_o}, 2'b01);
    run_cycle();
    clear_id();
    check("lu_cnt", StallCount_o, 1);
    load_use5(); RDAddr_EX = 0; RS2Addr_ID = 0;
    run_cycle();
    load_use5(); UseRS2_ID = 0;
    run_cycle();
    clear_id();
    check("no_stall_cnt", StallCount_o, 1);

    // branch depending on a load: two stalls, then taken flush
    Branch_ID = 1; RS1Addr_ID = 7; UseRS1_ID = 1; RDAddr_EX = 7; MemRead_EX = 1; RegWrite_EX = 1;
    run_cycle();
    RDAddr_EX = 0; MemRead_EX = 0; RegWrite_EX = 0; RDAddr_MEM = 7; MemRead_MEM = 1;
    run_cycle();
    RDAddr_MEM = 0; MemRead_MEM = 0; BranchTaken_ID = 1;
    #1 check("br_flush", IFIDFlush_o, 1);
    run_cycle();
    clear_id();
    check("br_stall_cnt", StallCount_o, 3);
    check("br_flush_cnt", FlushCount_o, 1);

    // memory wait with a concurrent load-use hazard
    load_use5(); MemReq_MEM = 1; MemAck_i = 0;
    repeat (3) begin
      #1 check("mw_freeze", {Freeze_o, IDEXBubble_o}, 2'b10);
      run_cycle();
    end
    MemAck_i = 1;
    #1 check("mw_ack", {Freeze_o, IDEXBubble_o}, 2'b01);
    run_cycle();
    clear_id();
    check("mw_cnt", StallCount_o, 7);
    run_cycle();

    // reset while waiting on memory
    MemReq_MEM = 1; MemAck_i = 0;
    run_cycle();
    rst_i = 1;
    run_cycle();
    rst_i = 0; clear_id();
    check("rst_ctrl", {PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, Freeze_o}, 0);
    check("rst_cnt", {StallCount_o, FlushCount_o}, 0);
    run_cycle();

    // saturation: bring stall count to all-ones-minus-1, then stall 3 more
    load_use5();
    repeat (CMAX - 1) run_cycle();
    check("sat_pre", StallCount_o, CMAX - 1);
    repeat (3) run_cycle();
    check("sat_max", StallCount_o, CMAX);
    clear_id();
    run_cycle();

    // random traffic on a small register window so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      rst_i          = ($urandom_range(499) == 0);
      start_i        = ($urandom_range(19) != 0);
      RS1Addr_ID     = 5'($urandom_range(3));
      RS2Addr_ID     = 5'($urandom_range(3));
      RDAddr_EX      = 5'($urandom_range(3));
      RDAddr_MEM     = 5'($urandom_range(3));
      UseRS1_ID      = 1'($urandom);
      UseRS2_ID      = 1'($urandom);
      Branch_ID      = 1'($urandom);
      BranchTaken_ID = 1'($urandom);
      RegWrite_EX    = 1'($urandom);
      MemRead_EX     = 1'($urandom);
      MemRead_MEM    = 1'($urandom);
      MemReq_MEM     = (m_mode == 2) ? 1'b1 : ($urandom_range(3) == 0);
      MemAck_i       = ($urandom_range(2) == 0);
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not end, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
